// File: rtl/cnt_pkg.sv
// Shared definitions for the mode_counter family: counting modes, direction
// encodings and a small helper that classifies modes by terminal behaviour.
package cnt_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3   // treated exactly like MODE_WRAP
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // True when the mode parks the count at the terminal value instead of wrapping.
    function automatic logic holds_at_terminal(input mode_e m);
        logic hold_s;
        case (m)
            MODE_SAT:     hold_s = 1'b1;
            MODE_ONESHOT: hold_s = 1'b1;
            MODE_WRAP:    hold_s = 1'b0;
            default:      hold_s = 1'b0;
        endcase
        return hold_s;
    endfunction

endpackage

// File: rtl/cnt_prescale.sv
// Input prescaler: divides enabled cycles by PRESCALE and emits a one-cycle
// tick on the last enabled cycle of each group. sync_rst restarts the group
// and suppresses the tick in that cycle. PRESCALE = 1 needs no state at all.
module cnt_prescale
    import cnt_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_rst,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // Clock and reset have no consumer when every enabled cycle is a tick.
            logic unused_s;
            assign unused_s = clk ^ rst_n;
            assign tick     = en & ~sync_rst;
        end else begin : g_div
            localparam int             PW   = $clog2(PRESCALE);
            localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);
            localparam logic [PW-1:0]  ZERO = {PW{1'b0}};
            localparam logic [PW-1:0]  ONE  = {{(PW-1){1'b0}}, 1'b1};

            logic [PW-1:0] phase_r;
            logic          last_s;

            assign last_s = (phase_r == LAST);
            assign tick   = en & ~sync_rst & last_s;

            // Phase counter: advances on enabled cycles, restarts after the tick.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    phase_r <= ZERO;
                end else if (sync_rst) begin
                    phase_r <= ZERO;
                end else if (en) begin
                    if (last_s) begin
                        phase_r <= ZERO;
                    end else begin
                        phase_r <= phase_r + ONE;
                    end
                end else begin
                    phase_r <= phase_r;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mode_counter.sv
// Parametrised event counter: prescaled up/down counting with wrap, saturate
// and one-shot modes, sync clear/load, registered terminal-count pulse and a
// sticky one-shot done flag.
module mode_counter
    import cnt_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               PRESCALE = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;
    logic             tc_r;
    logic             done_r;

    logic             tick_s;
    mode_e            mode_s;
    logic [WIDTH-1:0] term_s;
    logic [WIDTH-1:0] step_s;
    logic             hit_s;
    logic [WIDTH-1:0] cnt_nx_s;
    logic             tc_nx_s;
    logic             done_nx_s;

    cnt_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_rst (clr | load),
        .tick     (tick_s)
    );

    assign mode_s = mode_e'(mode);

    // Value the count would take on a tick, and whether that step enters the terminal value.
    always_comb begin
        step_s = cnt_r;
        term_s = (dir == DIR_DOWN) ? ZERO : max_val;
        if (dir == DIR_UP) begin
            // A count at or above max_val is treated as terminal, which covers loads past the bound.
            if (cnt_r < max_val) begin
                step_s = cnt_r + ONE;
            end else if (holds_at_terminal(mode_s)) begin
                step_s = cnt_r;
            end else begin
                step_s = ZERO;
            end
        end else begin
            if (cnt_r != ZERO) begin
                step_s = cnt_r - ONE;
            end else if (holds_at_terminal(mode_s)) begin
                step_s = cnt_r;
            end else begin
                step_s = max_val;
            end
        end
        hit_s = (step_s == term_s) && (cnt_r != term_s);
    end

    // Next-state selection with priority clr > load > tick > hold.
    always_comb begin
        cnt_nx_s  = cnt_r;
        tc_nx_s   = 1'b0;
        done_nx_s = done_r;
        if (clr) begin
            cnt_nx_s  = ZERO;
            done_nx_s = 1'b0;
        end else if (load) begin
            cnt_nx_s  = load_val;
            done_nx_s = 1'b0;
        end else if (tick_s && !done_r) begin
            cnt_nx_s  = step_s;
            tc_nx_s   = hit_s;
            done_nx_s = hit_s && (mode_s == MODE_ONESHOT);
        end else begin
            cnt_nx_s  = cnt_r;
            done_nx_s = done_r;
        end
    end

    // Count, terminal pulse and done flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= RST_VAL;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nx_s;
            tc_r   <= tc_nx_s;
            done_r <= done_nx_s;
        end
    end

    assign cnt  = cnt_r;
    assign tc   = tc_r;
    assign done = done_r;

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised, synthesizable event counter for the sim/RTL example set. It is the next generation of the free-running 4-bit wrap counter used in benches. It adds configurable width, an input prescaler, up/down direction, and wrap/saturate/one-shot modes, with sync clear and load. A terminal-count pulse and a sticky done flag let a bench or upstream logic end a run without polling the count value.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- PRESCALE, 1, enable cycles per counting step (≥1; 1 = step on every enabled cycle)
- RST_VAL, 0, value loaded into cnt on reset

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  count enable; prescaler advances only when high
- clr  in  1  sync clear: cnt←0, prescaler←0, done←0
- load  in  1  sync load: cnt←load_val, prescaler←0, done←0
- load_val  in  WIDTH  value for load
- dir  in  1  0 = up, 1 = down
- mode  in  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved (behaves as wrap)
- max_val  in  WIDTH  upper bound; also the reload value for down-wrap
- cnt  out  WIDTH  current count
- tc  out  1  one-cycle pulse on entry to the terminal value
- done  out  1  sticky; one-shot terminal reached

## Operation
- Reset values: cnt = RST_VAL, tc = 0, done = 0, prescaler = 0.
- tick = en & (prescaler == PRESCALE-1).
- The prescaler increments on each en cycle and returns to 0 on tick. It holds when en = 0.
- Per-cycle priority: clr > load > tick > hold. With clr or load, tc = 0 that cycle.
- Terminal value: up → max_val; down → 0.
- Up tick: if cnt < max_val, cnt+1. Otherwise cnt is at terminal, and the mode applies:
  - wrap → 0
  - saturate → hold
  - one-shot → hold
- Down tick: if cnt > 0, cnt−1. At 0, the mode applies:
  - wrap → max_val
  - saturate/one-shot → hold
- Loaded value above max_val while counting up: the next tick is treated as terminal, so wrap → 0 and saturate holds at the loaded value.
- tc is registered. It is 1 in the cycle where cnt first shows the terminal value after a step (cnt_next == terminal and cnt != terminal).
  - It does not re-pulse while holding.
  - In wrap mode it re-pulses every period.
  - A load directly to the terminal value does not pulse.
- One-shot: done is set together with tc. While done = 1, ticks are ignored (cnt frozen, tc = 0) until clr or load.
- dir, mode and max_val are sampled each tick. A change takes effect on the next tick; no pending state is kept.
- Arithmetic is unsigned modulo 2^WIDTH. No carry out.

## Timing
- Step latency: cnt updates on the clk edge where tick = 1. It is visible one cycle after the enabling edge.
- With PRESCALE = N and en held high, cnt changes every N cycles. The first change comes N edges after reset release, clr or load.
- tc and done are registered alongside cnt, with no combinational path from inputs.
- Asynchronous reset takes effect mid-run and immediately, regardless of prescaler phase. The first tick after release follows the rule above.
- clr and load asserted together: clr wins, so cnt = 0.

## Structure
- Shared package `cnt_pkg` holds:
  - mode enum: MODE_WRAP = 2'd0, MODE_SAT = 2'd1, MODE_ONESHOT = 2'd2
  - direction constants DIR_UP / DIR_DOWN
- Sub-module `cnt_prescale` (parameter PRESCALE; ports clk, rst_n, en, sync_rst, tick). At PRESCALE = 1 it degenerates to tick = en with no flops.
- The top module contains the next-state mux, terminal detection, and the tc/done registers.

## Test plan
- WIDTH=4, PRESCALE=1, max_val=15, up, wrap, en=1 from reset: cnt 0→15→0. tc high exactly in the cycles cnt==15. Run 40 cycles and check the period is 16.
- PRESCALE=3, max_val=5, down, saturate, load 5: cnt 5,4,…,0, changing every 3 cycles. A single tc when cnt reaches 0, then a 10-cycle hold at 0 with no further tc.
- One-shot up, max_val=7, load 4: done and tc rise together with cnt=7. Further ticks leave cnt=7 and tc=0. clr → cnt=0, done=0, and counting resumes.
- Priority: assert clr, load (load_val=9) and en in the same cycle → cnt=0. Next cycle load alone → cnt=9, tc=0.
- Load 12 with max_val=10, up, wrap → next tick gives cnt=0 and tc=0 (entry to 0 is not terminal for up).
- Async reset: drive rst_n low mid-prescale with cnt=6 → cnt=RST_VAL, tc=0 and done=0 immediately without a clock edge. After release, the first step comes PRESCALE enabled cycles later.
